main_memory_responder: RTL

//  Block-granular backing-memory model; the responder side of the cache controller's memory port.

---
 rtl/main_memory_responder.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/main_memory_responder.sv
// Block-granular backing memory that answers cache line fills and write-backs
// after a fixed latency, with a post-reset clear sweep and saturating op counters.
module main_memory_responder #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 512,
  parameter int NUM_BLOCKS = 256,
  parameter int LATENCY    = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] mem_address,
  input  logic [LINE_WIDTH-1:0] mem_write_data,
  input  logic                  mem_read_enable,
  input  logic                  mem_write_enable,
  output logic [LINE_WIDTH-1:0] mem_read_data,
  output logic                  mem_ready,
  output logic                  init_done,
  output logic [15:0]           read_count,
  output logic [15:0]           write_count
);

  localparam int               IDX_W    = $clog2(NUM_BLOCKS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BLOCKS - 1);
  localparam logic [7:0]       LAT_LOAD = 8'(LATENCY - 1);

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_BUSY,
    S_RESP,
    S_DRAIN
  } state_t;

  state_t                r_state;
  state_t                w_next;

  logic [LINE_WIDTH-1:0] r_mem [NUM_BLOCKS];

  logic [IDX_W-1:0]      r_sweep;
  logic                  r_init_done;
  logic [7:0]            r_lat;
  logic [IDX_W-1:0]      r_idx;
  logic [LINE_WIDTH-1:0] r_wdata;
  logic                  r_is_write;
  logic [LINE_WIDTH-1:0] r_rdata;
  logic                  r_ready;
  logic [15:0]           r_rd_cnt;
  logic [15:0]           r_wr_cnt;

  logic                  w_capture;
  logic                  w_do_op;
  logic                  w_mem_we;
  logic [IDX_W-1:0]      w_mem_idx;
  logic [LINE_WIDTH-1:0] w_mem_wdata;
  logic [LINE_WIDTH-1:0] w_mem_rdata;
  logic [IDX_W-1:0]      w_addr_idx;
  logic                  w_unused_addr;

  assign w_addr_idx    = mem_address[6 +: IDX_W];
  assign w_unused_addr = ^{mem_address[5:0], mem_address[ADDR_WIDTH-1:6+IDX_W]};
  assign w_mem_rdata   = r_mem[r_idx];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_INIT;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_capture   = 1'b0;
    w_do_op     = 1'b0;
    w_mem_we    = 1'b0;
    w_mem_idx   = r_idx;
    w_mem_wdata = r_wdata;
    case (r_state)
      S_INIT: begin
        w_mem_we    = 1'b1;
        w_mem_idx   = r_sweep;
        w_mem_wdata = '0;
        if (r_sweep == LAST_IDX) w_next = S_IDLE;
      end
      S_IDLE: begin
        if (mem_read_enable || mem_write_enable) begin
          w_capture = 1'b1;
          w_next    = S_BUSY;
        end
      end
      S_BUSY: begin
        if (r_lat == 8'd0) begin
          w_do_op  = 1'b1;
          w_mem_we = r_is_write;
          w_next   = S_RESP;
        end
      end
      S_RESP: begin
        w_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (!mem_read_enable && !mem_write_enable) w_next = S_IDLE;
      end
      default: w_next = S_INIT;
    endcase
  end

  // Storage has no reset; only the INIT sweep clears it.
  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[w_mem_idx] <= w_mem_wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sweep     <= '0;
      r_init_done <= 1'b0;
      r_lat       <= '0;
      r_idx       <= '0;
      r_wdata     <= '0;
      r_is_write  <= 1'b0;
      r_rdata     <= '0;
      r_ready     <= 1'b0;
      r_rd_cnt    <= '0;
      r_wr_cnt    <= '0;
    end else begin
      if (r_state == S_INIT) begin
        r_sweep <= r_sweep + 1'b1;
        if (r_sweep == LAST_IDX) r_init_done <= 1'b1;
      end

      if (w_capture) begin
        r_idx      <= w_addr_idx;
        r_wdata    <= mem_write_data;
        r_is_write <= mem_write_enable;
        r_lat      <= LAT_LOAD;
      end else if (r_state == S_BUSY && r_lat != 8'd0) begin
        r_lat <= r_lat - 8'd1;
      end

      if (w_do_op && !r_is_write) r_rdata <= w_mem_rdata;

      // Pulse is registered out of RESP, so it rises LATENCY+1 edges after capture
      // and the counters become visible on the same edge.
      r_ready <= (r_state == S_RESP);
      if (r_state == S_RESP) begin
        if (r_is_write) begin
          if (r_wr_cnt != 16'hFFFF) r_wr_cnt <= r_wr_cnt + 16'd1;
        end else begin
          if (r_rd_cnt != 16'hFFFF) r_rd_cnt <= r_rd_cnt + 16'd1;
        end
      end
    end
  end

  assign mem_read_data = r_rdata;
  assign mem_ready     = r_ready;
  assign init_done     = r_init_done;
  assign read_count    = r_rd_cnt;
  assign write_count   = r_wr_cnt;

endmodule
